// File: rtl/axi_gpio_multi.sv
// AXI4-Lite GPIO slave with NUM_CH channels of GPIO_WIDTH bits: output data, per-bit tri-state,
// two-flop synchronised inputs and an aggregated input-change level interrupt.
module axi_gpio_multi #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 9,
  parameter int          NUM_CH             = 2,
  parameter int          GPIO_WIDTH         = 32,
  parameter logic [31:0] DOUT_DEFAULT       = 32'h0,
  parameter logic [31:0] TRI_DEFAULT        = 32'hFFFFFFFF
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [NUM_CH*GPIO_WIDTH-1:0]    gpio_io_i,
  output logic [NUM_CH*GPIO_WIDTH-1:0]    gpio_io_o,
  output logic [NUM_CH*GPIO_WIDTH-1:0]    gpio_io_t,
  output logic                            ip2intc_irpt
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int GW     = GPIO_WIDTH;
  localparam int IO_W   = NUM_CH * GPIO_WIDTH;
  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [WORD_W-1:0] GIER_WORD = WORD_W'(32'h47);
  localparam logic [WORD_W-1:0] ISR_WORD  = WORD_W'(32'h48);
  localparam logic [WORD_W-1:0] IER_WORD  = WORD_W'(32'h4A);
  localparam logic [GW-1:0]     DOUT_RST  = DOUT_DEFAULT[GW-1:0];
  localparam logic [GW-1:0]     TRI_RST   = TRI_DEFAULT[GW-1:0];

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ACK = 2'd1, WR_RESP = 2'd2} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ACK = 2'd1, RD_DATA = 2'd2} rd_state_e;

  function automatic logic [DW-1:0] strb_to_mask(input logic [DW/8-1:0] strb);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < DW/8; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic awready_q, awready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d, rd_val_s, wmask_s;
  logic [GW-1:0] data_q [NUM_CH];
  logic [GW-1:0] data_d [NUM_CH];
  logic [GW-1:0] tri_q  [NUM_CH];
  logic [GW-1:0] tri_d  [NUM_CH];
  logic [IO_W-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_CH-1:0] isr_q, isr_d, ier_q, ier_d, chg_s;
  logic gier_q, gier_d, irq_q, irq_d, wr_en_s;
  logic [WORD_W-1:0] aw_word_s, ar_word_s;
  logic unused_addr_lsb_s;

  assign aw_word_s         = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_word_s         = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_addr_lsb_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign wmask_s           = strb_to_mask(s_axi_wstrb);
  assign wr_en_s           = (wr_state_q == WR_ACK) && s_axi_awvalid && s_axi_wvalid;

  // Write FSM next state: AW and W are only ever taken together.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (s_axi_awvalid && s_axi_wvalid && !bvalid_q) wr_state_d = WR_ACK;
               else wr_state_d = WR_IDLE;
      WR_ACK:  if (s_axi_awvalid && s_axi_wvalid) wr_state_d = WR_RESP;
               else wr_state_d = WR_IDLE;
      WR_RESP: if (s_axi_bready) wr_state_d = WR_IDLE;
               else wr_state_d = WR_RESP;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Write FSM outputs, registered alongside the state.
  always_comb begin
    awready_d = (wr_state_d == WR_ACK);
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (s_axi_arvalid && !rvalid_q) rd_state_d = RD_ACK;
               else rd_state_d = RD_IDLE;
      RD_ACK:  if (s_axi_arvalid) rd_state_d = RD_DATA;
               else rd_state_d = RD_IDLE;
      RD_DATA: if (s_axi_rready) rd_state_d = RD_IDLE;
               else rd_state_d = RD_DATA;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read FSM outputs; rdata is captured only on the AR handshake so it holds through back-pressure.
  always_comb begin
    arready_d = (rd_state_d == RD_ACK);
    rvalid_d  = (rd_state_d == RD_DATA);
    if (rd_state_q == RD_ACK && s_axi_arvalid) rdata_d = rd_val_s;
    else rdata_d = rdata_q;
  end

  // Read mux: DATA returns the synced pad for input bits and the output register otherwise.
  always_comb begin
    rd_val_s = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ar_word_s == WORD_W'(2*n))
        rd_val_s[GW-1:0] = (sync2_q[n*GW +: GW] & tri_q[n]) | (data_q[n] & ~tri_q[n]);
      else if (ar_word_s == WORD_W'(2*n+1))
        rd_val_s[GW-1:0] = tri_q[n];
      else
        rd_val_s = rd_val_s;
    end
    if (ar_word_s == GIER_WORD)     rd_val_s[DW-1]     = gier_q;
    else if (ar_word_s == ISR_WORD) rd_val_s[NUM_CH-1:0] = isr_q;
    else if (ar_word_s == IER_WORD) rd_val_s[NUM_CH-1:0] = ier_q;
    else rd_val_s = rd_val_s;
  end

  // Per-channel change event, restricted to bits configured as inputs.
  always_comb begin
    chg_s = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      chg_s[n] = |((sync2_q[n*GW +: GW] ^ prev_q[n*GW +: GW]) & tri_q[n]);
    end
  end

  // Register file next state; a change event overrides a same-cycle ISR toggle.
  always_comb begin
    gier_d = gier_q;
    ier_d  = ier_q;
    isr_d  = isr_q;
    for (int n = 0; n < NUM_CH; n++) begin
      data_d[n] = data_q[n];
      tri_d[n]  = tri_q[n];
      if (wr_en_s && aw_word_s == WORD_W'(2*n))
        data_d[n] = (data_q[n] & ~wmask_s[GW-1:0]) | (s_axi_wdata[GW-1:0] & wmask_s[GW-1:0]);
      else if (wr_en_s && aw_word_s == WORD_W'(2*n+1))
        tri_d[n] = (tri_q[n] & ~wmask_s[GW-1:0]) | (s_axi_wdata[GW-1:0] & wmask_s[GW-1:0]);
      else
        data_d[n] = data_q[n];
    end
    if (wr_en_s && aw_word_s == GIER_WORD)
      gier_d = (gier_q & ~wmask_s[DW-1]) | (s_axi_wdata[DW-1] & wmask_s[DW-1]);
    else if (wr_en_s && aw_word_s == IER_WORD)
      ier_d = (ier_q & ~wmask_s[NUM_CH-1:0]) | (s_axi_wdata[NUM_CH-1:0] & wmask_s[NUM_CH-1:0]);
    else if (wr_en_s && aw_word_s == ISR_WORD)
      isr_d = isr_q ^ (s_axi_wdata[NUM_CH-1:0] & wmask_s[NUM_CH-1:0]);
    else
      isr_d = isr_q;
    isr_d = isr_d | chg_s;
    irq_d = gier_q & (|(isr_q & ier_q));
  end

  // All state, including both FSMs and their registered handshake outputs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      gier_q     <= 1'b0;
      ier_q      <= '0;
      isr_q      <= '0;
      irq_q      <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        data_q[n] <= DOUT_RST;
        tri_q[n]  <= TRI_RST;
      end
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      sync1_q    <= gpio_io_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      gier_q     <= gier_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      irq_q      <= irq_d;
      for (int n = 0; n < NUM_CH; n++) begin
        data_q[n] <= data_d[n];
        tri_q[n]  <= tri_d[n];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pads
    assign gpio_io_o[g*GW +: GW] = data_q[g];
    assign gpio_io_t[g*GW +: GW] = tri_q[g];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign ip2intc_irpt  = irq_q;

endmodule
